// File: rtl/ahb_sram_responder_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the accepted-transfer record.
package ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned LANES      = 4;
  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_WAIT     = 3'd2,
    ST_WR_DONE  = 3'd3,
    ST_RD_DONE  = 3'd4,
    ST_ERR1     = 3'd5,
    ST_ERR2     = 3'd6
  } state_e;

  typedef struct packed {
    logic             write;
    logic [LANES-1:0] mask;
  } xfer_t;

  // NONSEQ and SEQ start a transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      default:                   trans_active = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_responder_lane_decode.sv
// Maps HSIZE and the low address bits to SRAM byte-lane enables and an alignment/size error.
module ahb_lane_decode
  import ahb_defs::*;
(
  input  logic [2:0]       hsize_i,
  input  logic [1:0]       addr_lo_i,
  output logic [LANES-1:0] mask_c,
  output logic             err_c
);

  always_comb begin
    mask_c = '0;
    err_c  = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: mask_c = LANES'(1) << addr_lo_i;
      HSIZE_HALF: begin
        mask_c = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        err_c  = addr_lo_i[0];
      end
      HSIZE_WORD: begin
        mask_c = 4'b1111;
        err_c  = (addr_lo_i != 2'b00);
      end
      default: err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite slave fronting a synchronous single-port SRAM with a fixed number of wait states.
module ahb_sram_responder
  import ahb_defs::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  MEM_EN,
  output logic [LANES-1:0]      MEM_WEA,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_DIN,
  input  logic [31:0]           MEM_DOUT
);

  state_e                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  xfer_t                  req_q, req_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic                   mem_en_q, mem_en_d;
  logic [LANES-1:0]       mem_wea_q, mem_wea_d;

  logic [LANES-1:0]       lane_mask_c;
  logic                   lane_err_c;
  logic                   accept_c;
  logic                   unused_haddr;

  // Upper address bits alias onto the SRAM.
  assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

  ahb_lane_decode u_lane_decode (
    .hsize_i   (HSIZE),
    .addr_lo_i (HADDR[1:0]),
    .mask_c    (lane_mask_c),
    .err_c     (lane_err_c)
  );

  assign accept_c = HSEL & trans_active(HTRANS) & HREADY;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      req_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      mem_en_q    <= 1'b0;
      mem_wea_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      mem_en_q    <= mem_en_d;
      mem_wea_q   <= mem_wea_d;
    end
  end

  // Next state; outputs are decoded from the state being entered so they register with it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    req_d       = req_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    mem_en_d    = 1'b0;
    mem_wea_d   = '0;

    case (state_q)
      ST_IDLE, ST_WR_DONE, ST_RD_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          addr_d     = HADDR[ADDR_WIDTH+1:2];
          req_d.write = HWRITE;
          req_d.mask  = lane_mask_c;
          if (lane_err_c) begin
            state_d = ST_ERR1;
          end else if (!HWRITE) begin
            state_d = ST_RD_ISSUE;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_WR_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_RD_ISSUE: begin
        if (WAIT_STATES == 0) begin
          state_d = ST_RD_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_CNT_W'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (cnt_q <= WAIT_CNT_W'(1)) begin
          state_d = req_q.write ? ST_WR_DONE : ST_RD_DONE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_RD_ISSUE: begin
        mem_en_d    = 1'b1;
        hreadyout_d = 1'b0;
      end
      ST_WAIT: hreadyout_d = 1'b0;
      ST_WR_DONE: begin
        mem_en_d  = 1'b1;
        mem_wea_d = req_d.mask;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      ST_ERR2: hresp_d = HRESP_ERROR;
      default: ;
    endcase
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WEA   = mem_wea_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_DIN   = HWDATA;
  assign HRDATA    = MEM_DOUT;

endmodule

// File: doc/ahb_sram_responder.md
# ahb_sram_responder

AHB-Lite responder that bridges the system AHB bus to a synchronous single-port SRAM word interface, with a parameterisable number of wait states. It sits on the slave side of the decoder and serves the transfers the core-side AHB master bridge issues. It accepts pipelined address and data phases and generates byte-lane write enables from HSIZE and HADDR. It returns the two-cycle ERROR response for illegal transfers.

## Interface
- ADDR_WIDTH, 10, SRAM word-address bits; the SRAM holds 4·2^ADDR_WIDTH bytes.
- WAIT_STATES, 0, extra HREADYOUT-low cycles per transfer; legal range 0..7.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  transfer address.
- HWRITE  in  1  1 = write, 0 = read.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; a previous data phase ends when HREADY is high.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data; equals MEM_DOUT.
- MEM_EN  out  1  SRAM enable.
- MEM_WEA  out  4  byte write enables; 0000 = read.
- MEM_ADDR  out  ADDR_WIDTH  SRAM word address.
- MEM_DIN  out  32  SRAM write data; equals HWDATA.
- MEM_DOUT  in  32  SRAM read data.
  - Valid the cycle after a read enable.
  - Held stable until the next enable.

## Operation
- Accept rule: a transfer is accepted in a cycle where HSEL & HTRANS[1] & HREADY are all high.
  - On accept, register the word address HADDR[ADDR_WIDTH+1:2], HWRITE, the byte-lane mask, and an error flag.
  - HADDR bits above ADDR_WIDTH+1 are ignored, so the address space aliases (wraps).
- IDLE/BUSY, or HSEL low, with HREADY high: no transfer; the next cycle returns a zero-wait OKAY.
- Lane mask:
  - byte: 1 << HADDR[1:0].
  - halfword: 0011 when HADDR[1]=0, 1100 when HADDR[1]=1.
  - word: 1111.
- Error flag is set for any of:
  - HSIZE > 010.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0] != 00.
- FSM states:
  - IDLE. HREADYOUT=1, HRESP=0.
  - RD_ISSUE. MEM_EN=1, MEM_WEA=0000, HREADYOUT=0.
  - WAIT. A counter loads WAIT_STATES and holds HREADYOUT=0 until it reaches 0.
  - WR_DONE. MEM_EN=1, MEM_WEA=mask, HREADYOUT=1.
  - RD_DONE. HREADYOUT=1.
  - ERR1. HREADYOUT=0, HRESP=1.
  - ERR2. HREADYOUT=1, HRESP=1.
- Transitions on accept (entered on the next cycle):
  - Error flag set → ERR1.
  - Read → RD_ISSUE.
  - Write with WAIT_STATES=0 → WR_DONE; otherwise → WAIT.
- Transitions out of the other states:
  - RD_ISSUE → WAIT if WAIT_STATES>0, else → RD_DONE.
  - WAIT → WR_DONE or RD_DONE when the counter reaches 0.
  - ERR1 → ERR2.
- Leaving WR_DONE, RD_DONE or ERR2:
  - Go back through the accept decision if a new transfer is accepted in that same cycle (pipelined back-to-back).
  - Otherwise → IDLE.
- An erroring transfer never asserts MEM_EN.
- Write data is taken from HWDATA in WR_DONE only.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, MEM_EN=0, MEM_WEA=0000, MEM_ADDR=0, FSM=IDLE, counter=0.
- Data-phase length, counting from the cycle after accept:
  - Write: 1+WAIT_STATES cycles.
  - Read: 2+WAIT_STATES cycles.
  - Error: exactly 2 cycles.
- Read-after-write to the same address returns the new data.
  - The write completes in WR_DONE.
  - The read issues no earlier than the following cycle.
- Reset asserted mid-transfer:
  - Outputs go to their reset values immediately (asynchronously).
  - The pending transfer is dropped and no SRAM write occurs.
- HSEL/HTRANS changes while HREADYOUT=0 are ignored, because HREADY is low.

## Structure
- Shared package/header ahb_defs:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE codes (BYTE, HALF, WORD).
  - HRESP codes (OKAY, ERROR).
  - FSM state encodings.
- One sub-module, ahb_lane_decode: combinational mapping of HSIZE and HADDR[1:0] to the 4-bit mask plus the error flag.

## Test plan
- Word write then read, WAIT_STATES=0:
  - Stimulus: write 0xDEADBEEF to 0x10, then read 0x10.
  - Write: MEM_WEA=1111 and MEM_ADDR=4 in the first data-phase cycle, HREADYOUT high.
  - Read: HREADYOUT low for 1 cycle, then HRDATA=0xDEADBEEF.
- Byte and halfword lane enables:
  - Byte write at 0x13 → MEM_WEA=1000.
  - Halfword write at 0x12 → MEM_WEA=1100.
- Misaligned transfer: word read at 0x02.
  - Response: HREADYOUT=0 with HRESP=1, then HREADYOUT=1 with HRESP=1.
  - MEM_EN stays 0 throughout.
- WAIT_STATES=3:
  - Write: HREADYOUT low for exactly 3 cycles.
  - Read: HREADYOUT low for exactly 4 cycles.
  - Back-to-back NONSEQs are accepted with no idle gap.
- Reset and IDLE:
  - Drive reset low during the WAIT of a write → no MEM_WEA pulse, HREADYOUT=1 immediately.
  - HTRANS=IDLE with HSEL=1 → zero-wait OKAY.
